// File: rtl/i2s_rx.sv
// I2S receiver: oversamples bclk/lrclk/data in the iclk domain and delivers
// left/right sample pairs through a valid/ready register with sticky error flags.
module i2s_rx #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             iclk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             io_i2s_bclk,
   input  logic             io_i2s_lrclk,
   input  logic             io_i2s_data,
   output logic [WIDTH-1:0] out_left,
   output logic [WIDTH-1:0] out_right,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             overrun,
   output logic             frame_err,
   input  logic             err_clr
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SYNC  = 2'd1,
      S_LEFT  = 2'd2,
      S_RIGHT = 2'd3
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [1:0]       r_bclk_s;
   logic [1:0]       r_lr_s;
   logic [1:0]       r_dat_s;
   logic             r_bclk_prev;
   logic             r_lr_prev;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-2:0] r_shift;
   logic [WIDTH-1:0] r_left_stage;
   logic             r_left_ok;
   logic [WIDTH-1:0] r_left;
   logic [WIDTH-1:0] r_right;
   logic             r_valid;
   logic             r_overrun;
   logic             r_frame_err;

   logic             w_lr;
   logic             w_dat;
   logic             w_edge;
   logic             w_chg;
   logic             w_run;
   logic             w_cap;
   logic             w_done;
   logic             w_short;
   logic             w_push;
   logic             w_load;
   logic [WIDTH-1:0] w_word;

   // Two-flop synchronizers plus previous bclk for rising-edge detection
   always_ff @(posedge iclk or negedge rst_n) begin
      if (!rst_n) begin
         r_bclk_s    <= 2'b00;
         r_lr_s      <= 2'b00;
         r_dat_s     <= 2'b00;
         r_bclk_prev <= 1'b0;
      end else begin
         r_bclk_s    <= {r_bclk_s[0], io_i2s_bclk};
         r_lr_s      <= {r_lr_s[0], io_i2s_lrclk};
         r_dat_s     <= {r_dat_s[0], io_i2s_data};
         r_bclk_prev <= r_bclk_s[1];
      end
   end

   assign w_lr    = r_lr_s[1];
   assign w_dat   = r_dat_s[1];
   assign w_edge  = r_bclk_s[1] & ~r_bclk_prev;
   assign w_chg   = w_edge & (w_lr != r_lr_prev);
   assign w_run   = (r_state == S_LEFT) || (r_state == S_RIGHT);
   assign w_cap   = w_edge & ~w_chg & w_run & (r_cnt < CW'(WIDTH));
   assign w_done  = w_cap & (r_cnt == CW'(WIDTH - 1));
   assign w_word  = {r_shift, w_dat};
   assign w_short = enable & w_chg & w_run & (r_cnt < CW'(WIDTH));
   // A right word only forms a pair when the left slot of the same frame was complete
   assign w_push  = enable & w_done & (r_state == S_RIGHT) & r_left_ok;
   assign w_load  = w_push & (~r_valid | out_ready);

   always_ff @(posedge iclk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (!enable) begin
         w_state_nxt = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:  w_state_nxt = S_SYNC;
            S_SYNC:  if (w_chg && !w_lr) w_state_nxt = S_LEFT;
            S_LEFT:  if (w_chg) w_state_nxt = S_RIGHT;
            S_RIGHT: if (w_chg) w_state_nxt = S_LEFT;
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   // Bit counter, shift register and left staging
   always_ff @(posedge iclk or negedge rst_n) begin
      if (!rst_n) begin
         r_lr_prev    <= 1'b0;
         r_cnt        <= '0;
         r_shift      <= '0;
         r_left_stage <= '0;
         r_left_ok    <= 1'b0;
      end else begin
         if (w_edge) r_lr_prev <= w_lr;
         if (!enable) begin
            r_cnt     <= '0;
            r_left_ok <= 1'b0;
         end else if (w_chg) begin
            r_cnt <= '0;
            if (!w_lr) r_left_ok <= 1'b0;
         end else if (w_cap) begin
            r_shift <= w_word[WIDTH-2:0];
            r_cnt   <= r_cnt + CW'(1);
            if (w_done && (r_state == S_LEFT)) begin
               r_left_stage <= w_word;
               r_left_ok    <= 1'b1;
            end
         end
      end
   end

   // Output pair register and sticky flags (set beats clear)
   always_ff @(posedge iclk or negedge rst_n) begin
      if (!rst_n) begin
         r_left      <= '0;
         r_right     <= '0;
         r_valid     <= 1'b0;
         r_overrun   <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         if (w_load) begin
            r_left  <= r_left_stage;
            r_right <= w_word;
            r_valid <= 1'b1;
         end else if (r_valid && out_ready) begin
            r_valid <= 1'b0;
         end
         if (w_push && r_valid && !out_ready) r_overrun <= 1'b1;
         else if (err_clr)                    r_overrun <= 1'b0;
         if (w_short)      r_frame_err <= 1'b1;
         else if (err_clr) r_frame_err <= 1'b0;
      end
   end

   assign out_left  = r_left;
   assign out_right = r_right;
   assign out_valid = r_valid;
   assign overrun   = r_overrun;
   assign frame_err = r_frame_err;

endmodule

// File: tb/tb_i2s_rx.sv
// Self-checking bench for i2s_rx: directed frame table, corner sequences and
// randomized frames checked against a frame-level expectation queue.
module tb_i2s_rx;

   localparam int unsigned W = 16;

   typedef struct {
      logic [W-1:0] l;
      logic [W-1:0] r;
   } pair_t;

   typedef struct {
      logic [W-1:0] l;
      logic [W-1:0] r;
      int           lnb;
      int           rnb;
      logic         pair;
      logic         ferr;
   } vec_t;

   logic         iclk = 1'b0;
   logic         rst_n, enable, bclk, lrclk, sdata, err_clr;
   logic         ready_man, rnd_bit, rand_mode;
   logic         out_ready_w;
   logic [W-1:0] out_left, out_right;
   logic         out_valid, overrun, frame_err;

   int    cyc = 0;
   int    n_checks = 0;
   int    n_fail = 0;
   int    n_rx = 0;
   int    rise_cyc = -1;
   int    last_bit_cyc = -1;
   logic  prev_valid = 1'b0;
   pair_t exp_q[$];
   vec_t  tbl[5];
   int    n0, exp_cnt, lnb, rnb;
   logic  any_short;
   logic [W-1:0] rl, rr;

   assign out_ready_w = rand_mode ? rnd_bit : ready_man;

   always #5 iclk = ~iclk;
   always @(posedge iclk) cyc <= cyc + 1;
   always @(posedge iclk) rnd_bit <= ($urandom_range(0, 3) != 0);

   i2s_rx #(.WIDTH(W)) dut (
      .iclk(iclk), .rst_n(rst_n), .enable(enable),
      .io_i2s_bclk(bclk), .io_i2s_lrclk(lrclk), .io_i2s_data(sdata),
      .out_left(out_left), .out_right(out_right), .out_valid(out_valid),
      .out_ready(out_ready_w), .overrun(overrun), .frame_err(frame_err),
      .err_clr(err_clr)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Scoreboard: every accepted pair must match the next expected frame
   always @(negedge iclk) begin : monitor
      pair_t p;
      if (rst_n) begin
         if (out_valid && !prev_valid) rise_cyc = cyc;
         if (out_valid && out_ready_w) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_pair: got %h/%h, expected no pair", out_left, out_right);
            end else begin
               p = exp_q.pop_front();
               check("pair_left", 32'(out_left), 32'(p.l));
               check("pair_right", 32'(out_right), 32'(p.r));
            end
            n_rx++;
         end
      end
      prev_valid = out_valid;
   end

   task automatic reset_pulse();
      #2 rst_n = 1'b0;
      #1;
      check("rst_pulse_flags", 32'({out_valid, overrun, frame_err}), 32'd0);
      check("rst_pulse_data", {out_left, out_right}, 32'd0);
      exp_q.delete();
      #2 rst_n = 1'b1;
   endtask

   // Bits first..nb-1 of one slot; bit 0 is the lrclk-change bit, bits 1..W carry MSB..LSB
   task automatic send_slot(input logic lr, input logic [W-1:0] w, input int nb,
                            input int first, input int en_at, input int rst_at);
      logic b;
      for (int i = first; i < nb; i++) begin
         @(posedge iclk);
         #1;
         if (i >= 1 && i <= W) b = w[W-i];
         else b = 1'($urandom_range(0, 1));
         bclk = 1'b0;
         lrclk = lr;
         sdata = b;
         if (i == en_at) enable = 1'b1;
         if (i == rst_at) reset_pulse();
         repeat (4) @(posedge iclk);
         #1;
         bclk = 1'b1;
         if (lr && i == W) last_bit_cyc = cyc;
         repeat (3) @(posedge iclk);
      end
   endtask

   task automatic send_frame(input logic [W-1:0] l, input logic [W-1:0] r,
                             input int ln, input int rn);
      send_slot(1'b0, l, ln, 1, -1, -1);
      send_slot(1'b1, r, rn, 0, -1, -1);
      send_slot(1'b0, '0, 1, 0, -1, -1);
   endtask

   task automatic settle(input int n);
      repeat (n) @(posedge iclk);
      #1;
   endtask

   task automatic pulse_clr();
      @(posedge iclk);
      #1 err_clr = 1'b1;
      @(posedge iclk);
      #1 err_clr = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; enable = 1'b1; bclk = 1'b0; lrclk = 1'b0; sdata = 1'b0;
      err_clr = 1'b0; ready_man = 1'b1; rand_mode = 1'b0;

      tbl[0] = '{16'h8001, 16'h7FFE, 32, 32, 1'b1, 1'b0};
      tbl[1] = '{16'hFFFF, 16'h0000, 17, 17, 1'b1, 1'b0};
      tbl[2] = '{16'h1234, 16'h5678, 16, 32, 1'b0, 1'b1};
      tbl[3] = '{16'hA5A5, 16'h5A5A, 32, 16, 1'b0, 1'b1};
      tbl[4] = '{16'hC3C3, 16'h3C3C, 11, 11, 1'b0, 1'b1};

      // Reset with the serial inputs toggling
      send_slot(1'b1, 16'hFFFF, 6, 0, -1, -1);
      send_slot(1'b0, 16'h5555, 6, 0, -1, -1);
      check("reset_flags", 32'({out_valid, overrun, frame_err}), 32'd0);
      check("reset_data", {out_left, out_right}, 32'd0);
      @(posedge iclk);
      #1 rst_n = 1'b1;
      send_slot(1'b1, W'($urandom), 32, 0, -1, -1);
      send_slot(1'b0, '0, 1, 0, -1, -1);
      settle(4);
      check("no_pair_before_frame", 32'(n_rx), 32'd0);
      check("valid_low_before_frame", 32'(out_valid), 32'd0);

      // First frame: values and latency from the last right bit
      n0 = n_rx;
      exp_q.push_back('{16'h8001, 16'h7FFE});
      send_frame(16'h8001, 16'h7FFE, 32, 32);
      settle(4);
      check("first_pair_count", 32'(n_rx - n0), 32'd1);
      check("latency", 32'(rise_cyc - last_bit_cyc), 32'd3);

      // Frame table: full, exact-width and short slots
      for (int k = 0; k < 5; k++) begin
         n0 = n_rx;
         if (tbl[k].pair) exp_q.push_back('{tbl[k].l, tbl[k].r});
         send_frame(tbl[k].l, tbl[k].r, tbl[k].lnb, tbl[k].rnb);
         settle(4);
         check($sformatf("tbl%0d_pairs", k), 32'(n_rx - n0), 32'(tbl[k].pair));
         check($sformatf("tbl%0d_ferr", k), 32'(frame_err), 32'(tbl[k].ferr));
         pulse_clr();
         settle(1);
         check($sformatf("tbl%0d_ferr_clr", k), 32'(frame_err), 32'd0);
      end

      // Overrun: consumer stalls across two frames
      ready_man = 1'b0;
      n0 = n_rx;
      exp_q.push_back('{16'h1234, 16'h5678});
      send_frame(16'h1234, 16'h5678, 32, 32);
      send_frame(16'hAAAA, 16'h5555, 32, 32);
      settle(4);
      check("ovr_valid", 32'(out_valid), 32'd1);
      check("ovr_hold", {out_left, out_right}, 32'h1234_5678);
      check("ovr_flag", 32'(overrun), 32'd1);
      pulse_clr();
      settle(1);
      check("ovr_clr", 32'(overrun), 32'd0);
      ready_man = 1'b1;
      settle(4);
      check("ovr_pairs", 32'(n_rx - n0), 32'd1);

      // lrclk toggles after 10 left bits, then a clean frame
      n0 = n_rx;
      send_frame(16'h1111, 16'h2222, 11, 32);
      settle(4);
      check("short_ferr", 32'(frame_err), 32'd1);
      check("short_no_pair", 32'(n_rx - n0), 32'd0);
      exp_q.push_back('{16'hBEEF, 16'hCAFE});
      send_frame(16'hBEEF, 16'hCAFE, 32, 32);
      settle(4);
      check("after_short_pair", 32'(n_rx - n0), 32'd1);
      pulse_clr();

      // Enable raised in the middle of a right slot
      enable = 1'b0;
      n0 = n_rx;
      send_slot(1'b0, 16'h0BAD, 32, 1, -1, -1);
      send_slot(1'b1, 16'hF00D, 32, 0, 10, -1);
      send_slot(1'b0, '0, 1, 0, -1, -1);
      settle(4);
      check("en_partial_ignored", 32'(n_rx - n0), 32'd0);
      exp_q.push_back('{16'h4321, 16'h8765});
      send_frame(16'h4321, 16'h8765, 32, 32);
      settle(4);
      check("en_first_pair", 32'(n_rx - n0), 32'd1);
      check("en_no_ferr", 32'(frame_err), 32'd0);

      // Short asynchronous reset pulse mid-word with a pair pending
      ready_man = 1'b0;
      send_frame(16'h0F0F, 16'hF0F0, 32, 32);
      settle(4);
      check("pre_rst_valid", 32'(out_valid), 32'd1);
      n0 = n_rx;
      send_slot(1'b0, 16'h1357, 32, 1, -1, 8);
      ready_man = 1'b1;
      send_slot(1'b1, 16'h2468, 32, 0, -1, -1);
      send_slot(1'b0, '0, 1, 0, -1, -1);
      settle(4);
      check("rst_partial_ignored", 32'(n_rx - n0), 32'd0);
      exp_q.push_back('{16'h7E57, 16'h0DD5});
      send_frame(16'h7E57, 16'h0DD5, 32, 32);
      settle(4);
      check("rst_resync_pair", 32'(n_rx - n0), 32'd1);

      // Randomized frames with random slot lengths and random ready
      rand_mode = 1'b1;
      n0 = n_rx;
      exp_cnt = 0;
      any_short = 1'b0;
      for (int k = 0; k < 16; k++) begin
         rl = W'($urandom);
         rr = W'($urandom);
         case ($urandom_range(0, 7))
            0: lnb = int'($urandom_range(4, W));
            1: lnb = W + 1;
            default: lnb = 32;
         endcase
         case ($urandom_range(0, 7))
            0: rnb = int'($urandom_range(4, W));
            1: rnb = W + 1;
            default: rnb = 32;
         endcase
         if (lnb >= W + 1 && rnb >= W + 1) begin
            exp_q.push_back('{rl, rr});
            exp_cnt++;
         end else begin
            any_short = 1'b1;
         end
         send_frame(rl, rr, lnb, rnb);
      end
      settle(50);
      check("rand_pairs", 32'(n_rx - n0), 32'(exp_cnt));
      check("rand_ferr", 32'(frame_err), 32'(any_short));
      check("rand_no_overrun", 32'(overrun), 32'd0);
      rand_mode = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
